// File: rtl/switch_event_pkg.sv
// Shared types and default constants for the switch event controller.
// Long-press support is built in when SWITCH_EVENT_LONGPRESS_EN is defined.
package switch_event_pkg;

  typedef enum logic [1:0] {
    RELEASE = 2'b00,
    PRESS   = 2'b01,
    LONG    = 2'b10
  } evt_kind_e;

  localparam int DEF_NUM_SW       = 4;
  localparam int DEF_TICK_DIV     = 25000;
  localparam int DEF_STABLE_TICKS = 10;
  localparam int DEF_LONG_TICKS   = 1000;

endpackage

// File: rtl/switch_event_ctrl_lane.sv
// One switch lane: 2-flop synchronizer, tick-based debounce counter
// and debounced level; flip_o marks the edge on which the level toggles.
module sw_debounce_lane
  import switch_event_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  input  logic tick_i,
  output logic state_o,
  output logic flip_o
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          mismatch;

  assign mismatch = sync_q[1] ^ state_q;
  assign flip_o   = tick_i && mismatch &&
                    (cnt_q == CW'(STABLE_TICKS - 1));
  assign state_o  = state_q;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (tick_i) begin
      if (!mismatch) begin
        cnt_d = '0;
      end else if (flip_o) begin
        cnt_d   = '0;
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sw_i};
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/switch_event_ctrl.sv
// Debounced switch bank with press/release (and optional long-press)
// events, round-robin arbitration; long-press gated by SWITCH_EVENT_LONGPRESS_EN.
module switch_event_ctrl
  import switch_event_pkg::*;
#(
  parameter int NUM_SW       = DEF_NUM_SW,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_SW-1:0]         i_sw,
  output logic [NUM_SW-1:0]         o_sw_state,
  output logic                      o_evt_valid,
  input  logic                      i_evt_ready,
  output logic [$clog2(NUM_SW)-1:0] o_evt_id,
  output logic [1:0]                o_evt_kind,
  output logic                      o_overflow
);

  localparam int ID_W = $clog2(NUM_SW);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [NUM_SW-1:0] flip;
  logic [NUM_SW-1:0] long_evt;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  for (genvar k = 0; k < NUM_SW; k++) begin : g_lane
    sw_debounce_lane #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_lane (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .sw_i   (i_sw[k]),
      .tick_i (tick),
      .state_o(o_sw_state[k]),
      .flip_o (flip[k])
    );
  end

`ifdef SWITCH_EVENT_LONGPRESS_EN
  localparam int LW = $clog2(LONG_TICKS + 1);

  logic [LW-1:0] lp_q [NUM_SW];
  logic [LW-1:0] lp_d [NUM_SW];

  // Saturates at LONG_TICKS so only one long-press fires per hold.
  always_comb begin
    for (int k = 0; k < NUM_SW; k++) begin
      lp_d[k]     = lp_q[k];
      long_evt[k] = 1'b0;
      if (!o_sw_state[k] || flip[k]) begin
        lp_d[k] = '0;
      end else if (tick && lp_q[k] != LW'(LONG_TICKS)) begin
        lp_d[k]     = lp_q[k] + LW'(1);
        long_evt[k] = (lp_q[k] == LW'(LONG_TICKS - 1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_SW; k++) lp_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SW; k++) lp_q[k] <= lp_d[k];
    end
  end
`else
  // LONG_TICKS only matters when long-press is built in.
  assign long_evt = (LONG_TICKS < 0) ? '1 : '0;
`endif

  logic [NUM_SW-1:0] pend_q, pend_d;
  evt_kind_e         kind_q [NUM_SW];
  evt_kind_e         kind_d [NUM_SW];
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   id_q, id_d;
  evt_kind_e         ekind_q, ekind_d;
  logic              ovf_q, ovf_d;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic              load;

  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      j = (int'(ptr_q) + i) % NUM_SW;
      if (!gnt_any && pend_q[j]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(j);
      end
    end
  end

  assign load = gnt_any && (!valid_q || i_evt_ready);

  always_comb begin
    logic taken;
    taken   = 1'b0;
    pend_d  = pend_q;
    kind_d  = kind_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    id_d    = id_q;
    ekind_d = ekind_q;
    ovf_d   = ovf_q;
    if (load) begin
      pend_d[gnt_id] = 1'b0;
      valid_d        = 1'b1;
      id_d           = gnt_id;
      ekind_d        = kind_q[gnt_id];
      ptr_d          = (gnt_id == ID_W'(NUM_SW - 1)) ?
                       '0 : gnt_id + ID_W'(1);
    end else if (valid_q && i_evt_ready) begin
      valid_d = 1'b0;
    end
    // A grant leaving on the same edge frees the slot for the new event.
    for (int k = 0; k < NUM_SW; k++) begin
      taken = load && (gnt_id == ID_W'(k));
      if (flip[k] || long_evt[k]) begin
        if (pend_q[k] && !taken) ovf_d = 1'b1;
        pend_d[k] = 1'b1;
        if (flip[k]) begin
          kind_d[k] = o_sw_state[k] ? RELEASE : PRESS;
        end else begin
          kind_d[k] = LONG;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
      pend_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ekind_q <= RELEASE;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NUM_SW; k++) kind_q[k] <= RELEASE;
    end else begin
      presc_q <= presc_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ekind_q <= ekind_d;
      ovf_q   <= ovf_d;
      kind_q  <= kind_d;
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_id    = id_q;
  assign o_evt_kind  = ekind_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Self-checking bench for switch_event_ctrl with a tick-level reference
// model; build with SWITCH_EVENT_LONGPRESS_EN to exercise long-press.
module tb_switch_event_ctrl;

  localparam int NSW  = 4;
  localparam int TDIV = 4;
  localparam int STB  = 3;
  localparam int LNG  = 8;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic [NSW-1:0] sw    = '0;
  logic           ready = 1'b0;
  logic [NSW-1:0] sw_state;
  logic           evt_valid;
  logic [1:0]     evt_id;
  logic [1:0]     evt_kind;
  logic           ovf;

  always #5 clk = ~clk;

  switch_event_ctrl #(
    .NUM_SW      (NSW),
    .TICK_DIV    (TDIV),
    .STABLE_TICKS(STB),
    .LONG_TICKS  (LNG)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sw       (sw),
    .o_sw_state (sw_state),
    .o_evt_valid(evt_valid),
    .i_evt_ready(ready),
    .o_evt_id   (evt_id),
    .o_evt_kind (evt_kind),
    .o_overflow (ovf)
  );

  typedef struct {
    int id;
    int kind;
    int cyc;
  } ev_t;

  int n_tests = 0;
  int n_fail  = 0;

  ev_t obs[$];
  int  exp_q[NSW][$];
  int  cyc_g  = 0;
  int  st_err = 0;

  // Reference model: debounced level is a run-length count of
  // mismatching ticks on the input delayed by the synchronizer.
  logic [NSW-1:0] h1 = '0, h2 = '0, st = '0, use_l;
  int  run[NSW];
  int  lp[NSW];
  int  mcyc = 0;
  bit  tick_m, flipped, st_old;
  ev_t e;

  always @(negedge clk) begin
    cyc_g++;
    if (sw_state !== st) st_err++;
    if (!rst && evt_valid && ready) begin
      e.id = int'(evt_id);
      e.kind = int'(evt_kind);
      e.cyc = cyc_g;
      obs.push_back(e);
    end
    if (rst) begin
      h1 = '0; h2 = '0; st = '0; mcyc = 0;
      for (int k = 0; k < NSW; k++) begin
        run[k] = 0;
        lp[k] = 0;
      end
    end else begin
      use_l = h2; h2 = h1; h1 = sw;
      tick_m = (mcyc == TDIV - 1);
      mcyc = (mcyc + 1) % TDIV;
      if (tick_m) begin
        for (int k = 0; k < NSW; k++) begin
          flipped = 1'b0;
          st_old = st[k];
          if (use_l[k] != st[k]) begin
            run[k]++;
            if (run[k] == STB) begin
              st[k] = ~st[k];
              run[k] = 0;
              flipped = 1'b1;
              exp_q[k].push_back(st[k] ? 1 : 0);
            end
          end else begin
            run[k] = 0;
          end
`ifdef SWITCH_EVENT_LONGPRESS_EN
          if (flipped || !st_old) begin
            lp[k] = 0;
          end else begin
            lp[k]++;
            if (lp[k] == LNG) exp_q[k].push_back(2);
          end
`endif
        end
      end
    end
  end

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    obs.delete();
    for (int k = 0; k < NSW; k++) exp_q[k].delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clocks(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    sw = '0;
    ready = 1'b0;
    rst = 1'b1;
    clocks(2);
    n_tests++;
    if (sw_state !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=0", sw_state);
    end
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got=%b want=0", evt_valid);
    end
    n_tests++;
    if (evt_id !== 2'd0 || evt_kind !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_evt got=%0d/%0d want=0/0", evt_id, evt_kind);
    end
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf got=%b want=0", ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_press();
    reset_dut();
    ready = 1'b1;
    sw = 4'b0010;
    clocks(30);
    n_tests++;
    if (sw_state !== 4'b0010) begin
      n_fail++;
      $display("FAIL press_state got=%b want=0010", sw_state);
    end
    n_tests++;
    if (obs.size() !== 1) begin
      n_fail++;
      $display("FAIL press_count got=%0d want=1", obs.size());
    end else begin
      n_tests++;
      if (obs[0].id !== 1 || obs[0].kind !== 1) begin
        n_fail++;
        $display("FAIL press_evt got=%0d/%0d want=1/1",
                 obs[0].id, obs[0].kind);
      end
    end
    sw = '0;
    clocks(30);
    n_tests++;
    if (obs.size() !== 2) begin
      n_fail++;
      $display("FAIL release_count got=%0d want=2", obs.size());
    end else begin
      n_tests++;
      if (obs[1].id !== 1 || obs[1].kind !== 0) begin
        n_fail++;
        $display("FAIL release_evt got=%0d/%0d want=1/0",
                 obs[1].id, obs[1].kind);
      end
    end
  endtask

  task automatic test_glitch();
    reset_dut();
    ready = 1'b1;
    sw = 4'b0001;
    clocks(8);
    sw = '0;
    clocks(30);
    n_tests++;
    if (sw_state !== 4'b0000) begin
      n_fail++;
      $display("FAIL glitch_state got=%b want=0000", sw_state);
    end
    n_tests++;
    if (obs.size() !== 0) begin
      n_fail++;
      $display("FAIL glitch_events got=%0d want=0", obs.size());
    end
  endtask

  task automatic test_back_to_back();
    int want_id[3];
    want_id[0] = 0; want_id[1] = 2; want_id[2] = 3;
    reset_dut();
    ready = 1'b1;
    sw = 4'b1101;
    clocks(30);
    sw = 4'b0000;
    clocks(30);
    n_tests++;
    if (obs.size() !== 6) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d want=6", obs.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (obs[i].id !== want_id[i % 3] ||
            obs[i].kind !== ((i < 3) ? 1 : 0)) begin
          n_fail++;
          $display("FAIL b2b_evt%0d got=%0d/%0d want=%0d/%0d", i,
                   obs[i].id, obs[i].kind, want_id[i % 3],
                   (i < 3) ? 1 : 0);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_tests++;
        if (obs[i].cyc !== obs[i-1].cyc + 1 ||
            obs[i+3].cyc !== obs[i+2].cyc + 1) begin
          n_fail++;
          $display("FAIL b2b_consec%0d got=%0d,%0d want=+1", i,
                   obs[i].cyc - obs[i-1].cyc,
                   obs[i+3].cyc - obs[i+2].cyc);
        end
      end
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    ready = 1'b0;
    sw = 4'b0001;
    clocks(30);
    n_tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_kind !== 2'd1) begin
      n_fail++;
      $display("FAIL ovf_hold0 got=%b/%0d/%0d want=1/0/1",
               evt_valid, evt_id, evt_kind);
    end
    sw = 4'b0101;
    clocks(30);
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_early got=%b want=0", ovf);
    end
    sw = 4'b0001;
    clocks(30);
    n_tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_kind !== 2'd1) begin
      n_fail++;
      $display("FAIL ovf_hold1 got=%b/%0d/%0d want=1/0/1",
               evt_valid, evt_id, evt_kind);
    end
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag got=%b want=1", ovf);
    end
    ready = 1'b1;
    clocks(6);
    n_tests++;
    if (obs.size() !== 2) begin
      n_fail++;
      $display("FAIL ovf_count got=%0d want=2", obs.size());
    end else begin
      n_tests++;
      if (obs[1].id !== 2 || obs[1].kind !== 0 || obs[0].id !== 0) begin
        n_fail++;
        $display("FAIL ovf_evt got=%0d/%0d,%0d want=2/0,0",
                 obs[1].id, obs[1].kind, obs[0].id);
      end
    end
    n_tests++;
    if (evt_valid !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drain got=%b/%b want=0/1", evt_valid, ovf);
    end
  endtask

  task automatic test_long();
`ifdef SWITCH_EVENT_LONGPRESS_EN
    int want_n = 2;
`else
    int want_n = 1;
`endif
    reset_dut();
    ready = 1'b1;
    sw = 4'b1000;
    clocks(70);
    n_tests++;
    if (obs.size() !== want_n) begin
      n_fail++;
      $display("FAIL long_count got=%0d want=%0d", obs.size(), want_n);
    end else begin
      n_tests++;
      if (obs[0].id !== 3 || obs[0].kind !== 1) begin
        n_fail++;
        $display("FAIL long_press got=%0d/%0d want=3/1",
                 obs[0].id, obs[0].kind);
      end
      if (want_n == 2) begin
        n_tests++;
        if (obs[1].id !== 3 || obs[1].kind !== 2) begin
          n_fail++;
          $display("FAIL long_evt got=%0d/%0d want=3/2",
                   obs[1].id, obs[1].kind);
        end
      end
    end
    clocks(40);
    n_tests++;
    if (obs.size() !== want_n) begin
      n_fail++;
      $display("FAIL long_once got=%0d want=%0d", obs.size(), want_n);
    end
    sw = '0;
    clocks(30);
    n_tests++;
    if (obs.size() !== want_n + 1) begin
      n_fail++;
      $display("FAIL long_rel got=%0d want=%0d", obs.size(), want_n + 1);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ready = 1'b0;
    sw = 4'b0100;
    clocks(30);
    n_tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      n_fail++;
      $display("FAIL rmid_pre got=%b/%0d want=1/2", evt_valid, evt_id);
    end
    rst = 1'b1;
    clocks(1);
    n_tests++;
    if (sw_state !== '0 || evt_valid !== 1'b0 || evt_id !== 2'd0 ||
        evt_kind !== 2'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_clear got=%b/%b/%0d/%0d/%b want=0",
               sw_state, evt_valid, evt_id, evt_kind, ovf);
    end
    rst = 1'b0;
    ready = 1'b1;
    clear_logs();
    clocks(30);
    n_tests++;
    if (sw_state !== 4'b0100 || obs.size() !== 1) begin
      n_fail++;
      $display("FAIL rmid_repress got=%b/%0d want=0100/1",
               sw_state, obs.size());
    end else begin
      n_tests++;
      if (obs[0].id !== 2 || obs[0].kind !== 1) begin
        n_fail++;
        $display("FAIL rmid_evt got=%0d/%0d want=2/1",
                 obs[0].id, obs[0].kind);
      end
    end
    sw = '0;
    clocks(30);
  endtask

  task automatic test_random();
    int len, n;
    reset_dut();
    ready = 1'b1;
    for (int s = 0; s < 60; s++) begin
      sw = NSW'($urandom_range(0, 15));
      len = $urandom_range(1, 48);
      clocks(len);
    end
    clocks(100);
    for (int k = 0; k < NSW; k++) begin
      n = 0;
      foreach (obs[i]) begin
        if (obs[i].id == k) begin
          if (n < exp_q[k].size()) begin
            n_tests++;
            if (obs[i].kind !== exp_q[k][n]) begin
              n_fail++;
              $display("FAIL rand_kind sw%0d #%0d got=%0d want=%0d",
                       k, n, obs[i].kind, exp_q[k][n]);
            end
          end
          n++;
        end
      end
      n_tests++;
      if (n !== exp_q[k].size()) begin
        n_fail++;
        $display("FAIL rand_count sw%0d got=%0d want=%0d",
                 k, n, exp_q[k].size());
      end
    end
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_ovf got=%b want=0", ovf);
    end
    n_tests++;
    if (st_err !== 0) begin
      n_fail++;
      $display("FAIL state_track got=%0d want=0 mismatching cycles",
               st_err);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_back_to_back();
    test_overflow();
    test_long();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
